// File: rtl/psdsqrt_pkg.sv
// Shared definitions for the sequential integer square root unit.
package psdsqrt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Smallest width able to hold values 0..value-1
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// One restoring square-root digit: shift two operand bits in, try {root,01}, subtract on success.
module psdsqrt_step
  import psdsqrt_pkg::*;
#(
  parameter int NBITS_OUT = 16
) (
  input  logic [NBITS_OUT+1:0] partial_rem_i,
  input  logic [NBITS_OUT-1:0] root_i,
  input  logic [1:0]           bits_i,
  output logic [NBITS_OUT+1:0] new_rem_o,
  output logic                 root_bit_o
);

  logic [NBITS_OUT+1:0] shifted_s;
  logic [NBITS_OUT+1:0] trial_s;
  logic                 unused_ok_s;

  // The partial remainder never exceeds 2*root, so its top two bits are always zero before the shift
  assign unused_ok_s = ^partial_rem_i[NBITS_OUT+1:NBITS_OUT];

  // Trial subtraction for one result bit
  always_comb begin
    shifted_s = {partial_rem_i[NBITS_OUT-1:0], bits_i};
    trial_s   = {root_i, 2'b01};
    if (shifted_s >= trial_s) begin
      new_rem_o  = shifted_s - trial_s;
      root_bit_o = 1'b1;
    end else begin
      new_rem_o  = shifted_s;
      root_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/psdsqrt_seq.sv
// Sequential integer square root, one root bit per clock, with busy/done handshake.
// Optional round-to-nearest of the root when SQRT_ROUND_EN is defined.
module psdsqrt_seq
  import psdsqrt_pkg::*;
#(
  parameter int NBITS_IN = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NBITS_IN-1:0]   xin,
  output logic                  busy,
  output logic                  done,
  output logic [NBITS_IN/2-1:0] sqrt,
  output logic [NBITS_IN/2:0]   rem
);

  localparam int NO = NBITS_IN / 2;
  localparam int CW = clog2(NO + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NBITS_IN-1:0] x_q, x_d;
  logic [NO+1:0]       prem_q, prem_d;
  logic [NO-1:0]       root_q, root_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NO-1:0]       sqrt_q, sqrt_d;
  logic [NO:0]         rem_q, rem_d;
  logic [NO+1:0]       step_rem_s;
  logic                step_bit_s;
  logic [NO-1:0]       final_root_s;

  psdsqrt_step #(.NBITS_OUT(NO)) u_step (
    .partial_rem_i (prem_q),
    .root_i        (root_q),
    .bits_i        (x_q[NBITS_IN-1 -: 2]),
    .new_rem_o     (step_rem_s),
    .root_bit_o    (step_bit_s)
  );

`ifdef SQRT_ROUND_EN
  // Round up when the remainder exceeds the root; an all-ones root saturates
  always_comb begin
    if ((prem_q[NO:0] > {1'b0, root_q}) && (root_q != {NO{1'b1}})) begin
      final_root_s = root_q + {{(NO-1){1'b0}}, 1'b1};
    end else begin
      final_root_s = root_q;
    end
  end
`else
  assign final_root_s = root_q;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    prem_d  = prem_q;
    root_d  = root_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sqrt_d  = sqrt_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          x_d     = xin;
          prem_d  = '0;
          root_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        x_d    = {x_q[NBITS_IN-3:0], 2'b00};
        prem_d = step_rem_s;
        root_d = {root_q[NO-2:0], step_bit_s};
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(NO - 1)) begin
          state_d = FINISH;
        end else begin
          state_d = CALC;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        sqrt_d  = final_root_s;
        rem_d   = prem_q[NO:0];
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset aborts any run in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      prem_q  <= '0;
      root_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sqrt_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      prem_q  <= prem_d;
      root_q  <= root_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sqrt_q  <= sqrt_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sqrt = sqrt_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Directed bench for psdsqrt_seq: 32-bit and 8-bit instances, SQRT_ROUND_EN-aware expectations.
module tb_psdsqrt_seq;

  logic        clk = 1'b0;
  logic        rst32, start32, busy32, done32;
  logic [31:0] xin32;
  logic [15:0] sqrt32;
  logic [16:0] rem32;
  logic        rst8, start8, busy8, done8;
  logic [7:0]  xin8;
  logic [3:0]  sqrt8;
  logic [4:0]  rem8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psdsqrt_seq #(.NBITS_IN(32)) dut32 (
    .clock(clk), .reset(rst32), .start(start32), .xin(xin32),
    .busy(busy32), .done(done32), .sqrt(sqrt32), .rem(rem32)
  );

  psdsqrt_seq #(.NBITS_IN(8)) dut8 (
    .clock(clk), .reset(rst8), .start(start8), .xin(xin8),
    .busy(busy8), .done(done8), .sqrt(sqrt8), .rem(rem8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mask/compare reference: set bit if x >= (r|m)^2
  function automatic logic [31:0] ref_root(input logic [31:0] x, input int nout);
    logic [31:0] r, t;
    r = 32'd0;
    for (int i = nout - 1; i >= 0; i--) begin
      t = r | (32'd1 << i);
      if ({32'd0, x} >= (64'(t) * 64'(t))) r = t;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] x, input int nout);
    logic [31:0] r, rm;
    r  = ref_root(x, nout);
    rm = x - r * r;
`ifdef SQRT_ROUND_EN
    if ((rm > r) && (r != ((32'd1 << nout) - 32'd1))) r = r + 32'd1;
`endif
    return r;
  endfunction

  task automatic run32(input string tag, input logic [31:0] x,
                       input logic [15:0] exp_s, input logic [16:0] exp_r);
    int c;
    @(posedge clk); #1;
    start32 = 1'b1; xin32 = x;
    @(posedge clk); #1;
    start32 = 1'b0; xin32 = 32'hDEAD_BEEF;
    c = 0;
    while (busy32 === 1'b1 && c < 100) begin
      c++;
      @(posedge clk); #1;
    end
    check({tag, "_busycyc"}, 64'(c), 64'd17);
    check({tag, "_done"}, 64'(done32), 64'd1);
    check({tag, "_sqrt"}, 64'(sqrt32), 64'(exp_s));
    check({tag, "_rem"}, 64'(rem32), 64'(exp_r));
  endtask

  initial begin
    int c;
    rst32 = 1'b1; rst8 = 1'b1; start32 = 1'b0; start8 = 1'b0;
    xin32 = 32'd0; xin8 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_sqrt", 64'(sqrt32), 64'd0);
    check("rst_rem", 64'(rem32), 64'd0);
    check("rst8_busy", 64'(busy8), 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;

    // Basic run, then done must drop and results hold
    run32("x123456", 32'd123456, 16'd351, 17'd255);
    @(posedge clk); #1;
    check("x123456_done_pulse", 64'(done32), 64'd0);
    check("x123456_hold", 64'(sqrt32), 64'd351);

    run32("x0", 32'd0, 16'd0, 17'd0);
    run32("xmax", 32'hFFFF_FFFF, 16'd65535, 17'd131070);
    run32("x12", 32'd12, 16'd3, 17'd3);
`ifdef SQRT_ROUND_EN
    run32("x13", 32'd13, 16'd4, 17'd4);
`else
    run32("x13", 32'd13, 16'd3, 17'd4);
`endif
    run32("x99", 32'd99, 16'(ref_out(32'd99, 16)), 17'd18);

    // Starts during CALC and FINISH are ignored
    @(posedge clk); #1;
    start32 = 1'b1; xin32 = 32'd123456;
    @(posedge clk); #1;
    start32 = 1'b0;
    c = 0;
    while (busy32 === 1'b1 && c < 100) begin
      c++;
      if (c == 5 || c == 16 || c == 17) begin
        start32 = 1'b1; xin32 = 32'd9;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start32 = 1'b0;
    check("ign_busycyc", 64'(c), 64'd17);
    check("ign_sqrt", 64'(sqrt32), 64'd351);
    check("ign_rem", 64'(rem32), 64'd255);
    @(posedge clk); #1;
    check("ign_noqueue", 64'(busy32), 64'd0);

    // Reset in CALC cycle 8 clears everything on that edge
    @(posedge clk); #1;
    start32 = 1'b1; xin32 = 32'd123456;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy32), 64'd1);
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_sqrt", 64'(sqrt32), 64'd0);
    check("midrst_rem", 64'(rem32), 64'd0);
    run32("x100", 32'd100, 16'd10, 17'd0);

    // 8-bit instance: single run on 200
    @(posedge clk); #1;
    start8 = 1'b1; xin8 = 8'd200;
    @(posedge clk); #1;
    start8 = 1'b0;
    c = 0;
    while (busy8 === 1'b1 && c < 100) begin
      c++;
      @(posedge clk); #1;
    end
    check("w8_x200_busycyc", 64'(c), 64'd5);
    check("w8_x200_done", 64'(done8), 64'd1);
    check("w8_x200_sqrt", 64'(sqrt8), 64'd14);
    check("w8_x200_rem", 64'(rem8), 64'd4);

    // 8-bit sweep with a start every 6 cycles
    start8 = 1'b1; xin8 = 8'd0;
    for (int v = 0; v < 256; v++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("w8_sweep_done", 64'(done8), 64'd1);
      check("w8_sweep_sqrt", 64'(sqrt8), 64'(ref_out(32'(v), 4)));
      check("w8_sweep_rem", 64'(rem8), 64'(32'(v) - ref_root(32'(v), 4) * ref_root(32'(v), 4)));
      if (v < 255) begin
        start8 = 1'b1; xin8 = 8'(v + 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
